// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor: diff_o = (a_i - b_i - bin_i) mod 2^WIDTH,
// processed LSB first, one bit per clock, through a single full-subtractor
// cell (two half subtractors plus an OR) with a registered borrow.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   start_i  : request a new operation (taken in IDLE or DONE only)
//   a_i      : minuend,    captured on the accepting edge
//   b_i      : subtrahend, captured on the accepting edge
//   bin_i    : borrow in,  captured on the accepting edge
//   busy_o   : high while the WIDTH bit pairs are being processed
//   valid_o  : one-cycle pulse, result outputs valid from this cycle
//   diff_o   : result, held until the next completion
//   bout_o   : borrow out, high iff a < b + bin
//   zero_o   : high iff diff_o == 0
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             zero_o
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_q;
    logic               br_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               valid_q;
    logic [WIDTH-1:0]   diff_q;
    logic               bout_q;
    logic               zero_q;

    // Full-subtractor cell on the current LSB pair.
    logic a_bit;
    logic b_bit;
    logic hs1_d;
    logic hs1_b;
    logic hs2_b;
    logic cell_d;
    logic cell_b;

    assign a_bit  = a_q[0];
    assign b_bit  = b_q[0];

    // First half subtractor: a - b.
    assign hs1_d  = a_bit ^ b_bit;
    assign hs1_b  = ~a_bit & b_bit;

    // Second half subtractor: (a - b) - borrow.
    assign cell_d = hs1_d ^ br_q;
    assign hs2_b  = ~hs1_d & br_q;

    // A borrow is generated by at most one of the two halves.
    assign cell_b = hs1_b | hs2_b;

    // Result register after this cycle's shift; on the final bit it is the
    // complete difference and goes straight to the output register.
    logic [WIDTH-1:0] res_d;
    assign res_d = {cell_d, res_q[WIDTH-1:1]};

    // Operand capture shared by IDLE and DONE, so a start held through DONE
    // launches the next operation without an idle cycle.
    logic accept;
    assign accept = start_i && ((state_q == IDLE) || (state_q == DONE));

    // NOTE: every register here, including the datapath shift registers, is
    // reset so an aborted operation leaves no partial state behind.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every read in this
            // block sees the pre-edge value of each register.
            valid_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        res_q   <= '0;
                        br_q    <= bin_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                SHIFT: begin
                    // start_i is deliberately not looked at here.
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_d;
                    br_q  <= cell_b;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        diff_q  <= res_d;
                        bout_q  <= cell_b;
                        zero_q  <= ~|res_d;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end

                // NOTE: the default arm keeps the encoding's spare value from
                // becoming a lock-up state.
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign diff_o  = diff_q;
    assign bout_o  = bout_q;
    assign zero_o  = zero_q;

endmodule
